// File: rtl/oht2bin_pipe.sv
// oht2bin_pipe: pipelined one-hot to binary encoder.
// The encoder is a SPLIT-ary reduction tree with one register stage per tree level.
// Each node carries an "any" bit and a partial binary index.
// Each stage has a valid bit, so stalls collapse bubbles and never drop data.
// Optional feature: define OHT2BIN_PIPE_ERR_EN to add multi-hot detection on m_err.
// Without that macro, m_err is tied low and m_bin is the bitwise OR of the set-bit indices.
// SPLIT is expected to be a power of two so that the concatenated child-select bits
// form a plain binary index.
module oht2bin_pipe #(
    parameter  int WIDTH     = 32,
    parameter  int SPLIT     = 2,
    localparam int WIDTH_LOG = $clog2(WIDTH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 s_vld,
    output logic                 s_rdy,
    input  logic [WIDTH-1:0]     s_oht,
    output logic                 m_vld,
    input  logic                 m_rdy,
    output logic [WIDTH_LOG-1:0] m_bin,
    output logic                 m_any,
    output logic                 m_err
);

    function automatic int calc_levels(input int w, input int s);
        int p;
        int l;
        p = 1;
        l = 0;
        for (int i = 0; i < 32; i++) begin
            if (p < w) begin
                p = p * s;
                l = l + 1;
            end
        end
        return l;
    endfunction

    localparam int LEVELS = calc_levels(WIDTH, SPLIT);
    localparam int SB     = $clog2(SPLIT);
    localparam int LEAVES = SPLIT ** LEVELS;

    logic [LEAVES-1:0]      leaf_any;
    logic [LEVELS-1:0]      vld;
    logic [LEVELS-1:0]      rdy;
    logic [LEVELS-1:0]      in_vld;
    logic [LEVELS-1:0]      ld;
    logic                   full_from;
    logic [LEVELS*SB-1:0]   top_idx;

    // Zero-extend the input to a full tree; padded leaves are never set.
    assign leaf_any = LEAVES'(s_oht);

    // A stage can take new data if it or any stage below it has a hole, or the sink is taking data.
    // This equals "empty or downstream advances" but has no combinational loop through rdy.
    always_comb begin
        full_from = 1'b1;
        rdy       = '0;
        for (int i = LEVELS - 1; i >= 0; i--) begin
            full_from = full_from & vld[i];
            rdy[i]    = m_rdy | ~full_from;
        end
    end

    // Each stage's incoming valid comes from the stage above, or from the upstream port for stage 0.
    always_comb begin
        in_vld    = '0;
        in_vld[0] = s_vld;
        for (int i = 1; i < LEVELS; i++) begin
            in_vld[i] = vld[i-1];
        end
    end

    assign ld    = rdy & in_vld;
    assign s_rdy = rdy[0];
    assign m_vld = vld[LEVELS-1];

    // Stage valid bits shift forward whenever a stage is allowed to load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld <= '0;
        end else begin
            for (int i = 0; i < LEVELS; i++) begin
                if (rdy[i]) begin
                    vld[i] <= in_vld[i];
                end
            end
        end
    end

    for (genvar g = 0; g < LEVELS; g++) begin : lvl
        localparam int NN = SPLIT ** (LEVELS - 1 - g);
        localparam int NW = (g + 1) * SB;

        logic [NN-1:0]         any_d;
        logic [NN-1:0]         any_q;
        logic [NN-1:0][NW-1:0] idx_d;
        logic [NN-1:0][NW-1:0] idx_q;
`ifdef OHT2BIN_PIPE_ERR_EN
        logic [NN-1:0]         err_d;
        logic [NN-1:0]         err_q;
`endif

        if (g == 0) begin : g_comb
            // The first level encodes groups of raw leaves.
            // The child-select bits alone form the index.
            always_comb begin
                any_d = '0;
                idx_d = '0;
`ifdef OHT2BIN_PIPE_ERR_EN
                err_d = '0;
`endif
                for (int n = 0; n < NN; n++) begin
                    for (int c = 0; c < SPLIT; c++) begin
`ifdef OHT2BIN_PIPE_ERR_EN
                        if (leaf_any[n*SPLIT+c] && any_d[n]) begin
                            err_d[n] = 1'b1;
                        end
`endif
                        if (leaf_any[n*SPLIT+c]) begin
                            any_d[n] = 1'b1;
                            idx_d[n] = idx_d[n] | NW'(c);
                        end
                    end
                end
            end
        end else begin : g_comb
            localparam int CW = g * SB;

            logic [NN*SPLIT-1:0]         c_any;
            logic [NN*SPLIT-1:0][CW-1:0] c_idx;
            assign c_any = lvl[g-1].any_q;
            assign c_idx = lvl[g-1].idx_q;
`ifdef OHT2BIN_PIPE_ERR_EN
            logic [NN*SPLIT-1:0]         c_err;
            assign c_err = lvl[g-1].err_q;
`endif

            // Each node takes the child-select bits as its upper index bits.
            // Its lower index bits are the OR of the indices of the children that are active.
            always_comb begin
                any_d = '0;
                idx_d = '0;
`ifdef OHT2BIN_PIPE_ERR_EN
                err_d = '0;
`endif
                for (int n = 0; n < NN; n++) begin
                    for (int c = 0; c < SPLIT; c++) begin
`ifdef OHT2BIN_PIPE_ERR_EN
                        if (c_err[n*SPLIT+c] || (c_any[n*SPLIT+c] && any_d[n])) begin
                            err_d[n] = 1'b1;
                        end
`endif
                        if (c_any[n*SPLIT+c]) begin
                            any_d[n] = 1'b1;
                            idx_d[n] = idx_d[n] | {SB'(c), c_idx[n*SPLIT+c]};
                        end
                    end
                end
            end
        end

        // The stage register only captures data when a transfer actually moves into it.
        // Its contents therefore stay stable during a stall.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                any_q <= '0;
                idx_q <= '0;
`ifdef OHT2BIN_PIPE_ERR_EN
                err_q <= '0;
`endif
            end else if (ld[g]) begin
                any_q <= any_d;
                idx_q <= idx_d;
`ifdef OHT2BIN_PIPE_ERR_EN
                err_q <= err_d;
`endif
            end
        end
    end

    assign top_idx = lvl[LEVELS-1].idx_q[0];
    assign m_bin   = top_idx[WIDTH_LOG-1:0];
    assign m_any   = lvl[LEVELS-1].any_q[0];
`ifdef OHT2BIN_PIPE_ERR_EN
    assign m_err   = lvl[LEVELS-1].err_q[0];
`else
    assign m_err   = 1'b0;
`endif

endmodule

// File: doc/oht2bin_pipe.md
OHT2BIN_PIPE -- requirements
Module: oht2bin_pipe

Interface
REQ-001 Parameter WIDTH, default 32: one-hot input width; SHALL be >= 2.
REQ-002 Parameter SPLIT, default 2: tree radix; SHALL be >= 2.
REQ-003 Local parameter WIDTH_LOG = $clog2(WIDTH): binary output width.
REQ-004 Local parameter LEVELS = ceil(log_SPLIT(WIDTH)): tree depth, equal to the pipeline depth.
REQ-005 Clock and reset: one clock; reset is asynchronous and active-low.
- clk  input  1  clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
REQ-006 Upstream interface:
- s_vld  input  1  input transfer valid.
- s_rdy  output  1  block can accept a transfer.
- s_oht  input  WIDTH  one-hot vector.
REQ-007 Downstream interface:
- m_vld  output  1  output transfer valid.
- m_rdy  input  1  downstream accepts.
- m_bin  output  WIDTH_LOG  index of the set bit.
- m_any  output  1  at least one input bit was set.
- m_err  output  1  more than one input bit was set (see REQ-021).

Function
REQ-008 A transfer SHALL occur on a clock edge where s_vld and s_rdy are both high; likewise on the output side where m_vld and m_rdy are both high.
REQ-009 Encoding SHALL be a SPLIT-ary tree of LEVELS levels with one register stage per level.
- Each level combines groups of SPLIT nodes.
- Each node carries: the OR of its inputs (any), the partial binary index, and an error bit.
REQ-010 Partial index per level: the child-select bits from a SPLIT-input one-hot-to-binary encode SHALL be concatenated above the OR of the child indices masked by the child any bits.
REQ-011 Padding: WIDTH SHALL be zero-extended to SPLIT**LEVELS; padded bits SHALL contribute nothing.
REQ-012 Latency: with m_rdy held high, a transfer SHALL appear on m_* exactly LEVELS cycles after acceptance (5 cycles for WIDTH=32, SPLIT=2).
REQ-013 Throughput: one transfer per cycle when m_rdy is continuously high.
REQ-014 Each stage SHALL hold a valid bit and SHALL load when it is empty or when its downstream stage advances in the same cycle.
- s_rdy = ~vld[0] | advance[0].
- m_vld = vld[LEVELS-1].
REQ-015 Stall: while m_vld=1 and m_rdy=0, m_bin, m_any and m_err SHALL hold stable.
- Bubbles SHALL collapse: earlier stages keep loading until every stage is full.
REQ-016 Zero input: s_oht = 0 SHALL produce m_any=0, m_bin=0, m_err=0.
REQ-017 The block SHALL NOT drop, duplicate or reorder transfers.
REQ-018 Combinational paths: s_rdy SHALL depend only on stage valid bits and m_rdy; there SHALL be no path from s_oht to any output.

Reset
REQ-019 While rst_n=0, all stage valid bits SHALL be cleared asynchronously.
- Data registers SHALL clear to 0.
- Resulting outputs: m_vld=0, m_bin=0, m_any=0, m_err=0, s_rdy=1.
REQ-020 Reset mid-operation SHALL discard every in-flight transfer; after rst_n deasserts, the first accepted transfer SHALL emerge after LEVELS cycles.

Configuration
REQ-021 Macro OHT2BIN_PIPE_ERR_EN controls multi-hot error detection.
- Defined: a node's err = OR of the child err bits, OR more than one child any bit set. m_err reports multi-hot input and m_bin is unspecified when m_err=1.
- Undefined: err logic and registers SHALL be absent, m_err SHALL be tied to 0, and m_bin SHALL equal the bitwise OR of the indices of all set bits.

Verification
REQ-022 The bench SHALL cover the following directed scenarios (WIDTH=32, SPLIT=2 unless stated):
- Reset: rst_n=0 -> m_vld=0, s_rdy=1, m_bin=0.
- Walking one: s_oht=1<<i for i=0..31 back-to-back, m_rdy=1 -> m_bin=i, m_any=1, m_err=0, each 5 cycles after acceptance, one per cycle.
- Zero input: s_oht=0 -> m_any=0, m_bin=0.
- Backpressure: m_rdy=0 for 10 cycles during a stream of 8 transfers -> s_rdy drops after 5 accepted, outputs held stable, all 8 delivered in order once m_rdy=1.
- Multi-hot with OHT2BIN_PIPE_ERR_EN: s_oht=32'h0000_0011 -> m_err=1. Without the macro: m_err=0 and m_bin=4 (0|4).
- Odd size: WIDTH=5, SPLIT=4 -> LEVELS=2; s_oht=5'b10000 -> m_bin=4 after 2 cycles.
- Reset mid-stream: rst_n pulsed low while 3 transfers are in flight -> none emerge; the next accepted transfer emerges after 5 cycles.
